divremiter: RTL and testbench

// - Iterative radix-2 restoring integer divider/remainder unit.
// - Counterpart of the pipelined multiplier in the MDU: executes RISC-V M-extension
//   DIV, DIVU, REM and REMU.
// - Accepts operands from the Execute-stage forwarding muxes and produces one bit of

---
 rtl/divremiter_if.sv | 25 ++
 rtl/divremiter.sv | 129 ++++++++++++
 tb/tb_divremiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/divremiter_if.sv
// Operand/result bundle between the Execute stage and the iterative divider.
// The master drives the request and operands; the slave returns status and result.
interface divremiter_if #(
    parameter int XLEN = 64
);
    logic            StartE;
    logic            FlushE;
    logic            AckE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic            DivBusyE;
    logic            DivDoneE;
    logic [XLEN-1:0] ResultE;

    modport master (
        output StartE, FlushE, AckE, Funct3E, ForwardedSrcAE, ForwardedSrcBE,
        input  DivBusyE, DivDoneE, ResultE
    );

    modport slave (
        input  StartE, FlushE, AckE, Funct3E, ForwardedSrcAE, ForwardedSrcBE,
        output DivBusyE, DivDoneE, ResultE
    );
endinterface

// File: rtl/divremiter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// The result is held in DONE until acknowledged and stays on ResultE afterwards.
module divremiter #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    divremiter_if.slave  dif
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_BUSY = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]      state_reg, state_next;
    logic [1:0]      op_reg;
    logic            signed_reg;
    logic            negq_reg, negr_reg;
    logic [XLEN-1:0] a_reg, b_reg;
    logic [XLEN-1:0] rem_reg, quo_reg;
    logic [XLEN-1:0] result_reg;
    logic [CW-1:0]   cnt_reg;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;
    logic [XLEN:0]   rem_wide, trial;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign a_neg    = signed_reg & a_reg[XLEN-1];
    assign b_neg    = signed_reg & b_reg[XLEN-1];
    assign abs_a    = a_neg ? (~a_reg + 1'b1) : a_reg;
    assign abs_b    = b_neg ? (~b_reg + 1'b1) : b_reg;
    assign div_zero = (b_reg == '0);
    assign div_ovf  = signed_reg && (a_reg == {1'b1, {(XLEN-1){1'b0}}}) && (b_reg == '1);

    // The shifted-out quotient MSB is kept as a carry so a partial remainder at or
    // above 2^(XLEN-1) is not truncated when the divisor is large (unsigned ops).
    assign rem_wide = {rem_reg, quo_reg[XLEN-1]};
    assign trial    = rem_wide - {1'b0, b_reg};

    assign quo_fix  = negq_reg ? (~quo_reg + 1'b1) : quo_reg;
    assign rem_fix  = negr_reg ? (~rem_reg + 1'b1) : rem_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (dif.StartE) state_next = S_PREP;
            S_PREP: state_next = (div_zero || div_ovf) ? S_DONE : S_BUSY;
            S_BUSY: if (cnt_reg == '0) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: if (dif.AckE) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (dif.FlushE) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            signed_reg <= 1'b0;
            negq_reg   <= 1'b0;
            negr_reg   <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (!dif.FlushE) begin
                case (state_reg)
                    S_IDLE: begin
                        if (dif.StartE) begin
                            op_reg     <= dif.Funct3E[1:0];
                            signed_reg <= ~dif.Funct3E[0];
                            a_reg      <= dif.ForwardedSrcAE;
                            b_reg      <= dif.ForwardedSrcBE;
                        end
                    end
                    S_PREP: begin
                        negq_reg <= a_neg ^ b_neg;
                        negr_reg <= a_neg;
                        if (div_zero) begin
                            quo_reg    <= '1;
                            rem_reg    <= a_reg;
                            result_reg <= op_reg[1] ? a_reg : '1;
                        end else if (div_ovf) begin
                            quo_reg    <= a_reg;
                            rem_reg    <= '0;
                            result_reg <= op_reg[1] ? '0 : a_reg;
                        end else begin
                            b_reg   <= abs_b;
                            quo_reg <= abs_a;
                            rem_reg <= '0;
                            cnt_reg <= CNT_LAST;
                        end
                    end
                    S_BUSY: begin
                        if (!trial[XLEN]) begin
                            rem_reg <= trial[XLEN-1:0];
                            quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                        end else begin
                            rem_reg <= rem_wide[XLEN-1:0];
                            quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                        end
                        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                    end
                    S_FIX: begin
                        quo_reg    <= quo_fix;
                        rem_reg    <= rem_fix;
                        result_reg <= op_reg[1] ? rem_fix : quo_fix;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dif.DivBusyE = (state_reg == S_PREP) || (state_reg == S_BUSY) || (state_reg == S_FIX);
    assign dif.DivDoneE = (state_reg == S_DONE);
    assign dif.ResultE  = result_reg;
endmodule

// File: tb/tb_divremiter.sv
// Directed bench for divremiter at XLEN=32: arithmetic, special cases, latency,
// handshake, flush and asynchronous reset.
module tb_divremiter;
    localparam int XLEN = 32;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    divremiter_if #(.XLEN(XLEN)) dif ();

    divremiter #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dif     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an op at a negedge, count edges until DivDoneE, check latency/result,
    // then acknowledge and check that ResultE survives the return to IDLE.
    // poke > 0 asserts StartE with junk operands during that cycle (must be ignored).
    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_cyc, input int poke);
        int cyc;
        bit got;
        @(negedge clk);
        dif.Funct3E        = f3;
        dif.ForwardedSrcAE = a;
        dif.ForwardedSrcBE = b;
        dif.StartE         = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            dif.StartE = (cyc == poke);
            if (cyc == poke) begin
                dif.ForwardedSrcAE = 32'h0000_0055;
                dif.ForwardedSrcBE = 32'h0000_0001;
            end
            if (dif.DivDoneE) got = 1;
        end
        dif.StartE = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s latency: no DivDoneE within %0d cycles, required cycle %0d", name, cyc, exp_cyc);
        end else if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: DivDoneE at cycle %0d, required %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (dif.ResultE !== exp_res) begin
            errors++;
            $display("FAIL %s result: got 0x%08h, required 0x%08h", name, dif.ResultE, exp_res);
        end
        checks++;
        if (dif.DivBusyE !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b, required 0", name, dif.DivBusyE);
        end
        dif.AckE = 1'b1;
        @(negedge clk);
        dif.AckE = 1'b0;
        checks++;
        if (dif.DivDoneE !== 1'b0 || dif.ResultE !== exp_res) begin
            errors++;
            $display("FAIL %s after_ack: done=%b result=0x%08h, required done=0 result=0x%08h",
                     name, dif.DivDoneE, dif.ResultE, exp_res);
        end
        $display("op %s A=0x%08h B=0x%08h -> 0x%08h (expected 0x%08h) cycle %0d", name, a, b, dif.ResultE, exp_res, cyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dif.DivBusyE !== 1'b0 || dif.DivDoneE !== 1'b0 || dif.ResultE !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=0x%08h, required 0 0 0",
                     dif.DivBusyE, dif.DivDoneE, dif.ResultE);
        end
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset: busy=%b done=%b result=0x%08h", dif.DivBusyE, dif.DivDoneE, dif.ResultE);
    endtask

    task automatic test_arith();
        run_op("DIV -7/2",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, 0);
        run_op("REM -7%2",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35, 0);
        run_op("REMU 100%7",    3'b111, 32'd100,       32'd7,         32'd2,         35, 0);
        run_op("DIVU 100/7",    3'b101, 32'd100,       32'd7,         32'h0000_000E, 35, 0);
        run_op("DIV 7/-2",      3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0);
        run_op("REM 7%-2",      3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         35, 0);
        run_op("DIVU big",      3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         35, 0);
        run_op("REMU big",      3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 35, 0);
        run_op("DIV -100/-7",   3'b000, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        35, 0);
    endtask

    task automatic test_special();
        run_op("DIVU x/0",      3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 2, 0);
        run_op("DIV x/0",       3'b100, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 2, 0);
        run_op("REM x%0",       3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 2, 0);
        run_op("DIV ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
        run_op("REM ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);
        run_op("DIVU 8000/-1",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35, 0);
    endtask

    task automatic test_start_while_busy();
        run_op("DIVU poke5", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 35, 5);
        run_op("REMU poke1", 3'b111, 32'd100, 32'd7, 32'd2,         35, 1);
    endtask

    task automatic test_flush();
        int  cyc;
        bit  saw_done;
        @(negedge clk);
        dif.Funct3E = 3'b101; dif.ForwardedSrcAE = 32'd100; dif.ForwardedSrcBE = 32'd7;
        dif.StartE  = 1'b1;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            dif.StartE = 1'b0;
        end
        checks++;
        if (dif.DivBusyE !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_before: got %b, required 1", dif.DivBusyE);
        end
        dif.FlushE = 1'b1;
        @(negedge clk);
        dif.FlushE = 1'b0;
        checks++;
        if (dif.DivBusyE !== 1'b0 || dif.DivDoneE !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b done=%b, required 0 0", dif.DivBusyE, dif.DivDoneE);
        end
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.DivDoneE || dif.DivBusyE) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL flush_no_result: activity seen after flush, required none");
        end
        $display("flush: busy=%b done=%b after 40 idle cycles", dif.DivBusyE, dif.DivDoneE);
        run_op("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 35, 0);
    endtask

    task automatic test_hold_and_ack_start();
        int  cyc;
        bit  unstable;
        @(negedge clk);
        dif.Funct3E = 3'b100; dif.ForwardedSrcAE = 32'hFFFF_FFF9; dif.ForwardedSrcBE = 32'd2;
        dif.StartE  = 1'b1;
        cyc = 0;
        while (!dif.DivDoneE && cyc < 100) begin
            @(negedge clk);
            dif.StartE = 1'b0;
            cyc++;
        end
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            dif.StartE = 1'b1;
            dif.ForwardedSrcAE = 32'd50; dif.ForwardedSrcBE = 32'd5;
            @(negedge clk);
            if (dif.DivDoneE !== 1'b1 || dif.ResultE !== 32'hFFFF_FFFD) unstable = 1;
        end
        checks++;
        if (unstable || cyc >= 100) begin
            errors++;
            $display("FAIL done_hold: done=%b result=0x%08h, required 1 0xfffffffd", dif.DivDoneE, dif.ResultE);
        end
        dif.AckE = 1'b1;
        @(negedge clk);
        dif.AckE = 1'b0;
        dif.StartE = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.DivBusyE !== 1'b0 || dif.DivDoneE !== 1'b0 || dif.ResultE !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL ack_start_ignored: busy=%b done=%b result=0x%08h, required 0 0 0xfffffffd",
                     dif.DivBusyE, dif.DivDoneE, dif.ResultE);
        end
        $display("hold: result=0x%08h held 5 cycles, start with ack ignored busy=%b", dif.ResultE, dif.DivBusyE);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        dif.Funct3E = 3'b101; dif.ForwardedSrcAE = 32'd1000; dif.ForwardedSrcBE = 32'd3;
        dif.StartE  = 1'b1;
        @(negedge clk);
        dif.StartE = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (dif.DivBusyE !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy_before: got %b, required 1", dif.DivBusyE);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (dif.DivBusyE !== 1'b0 || dif.DivDoneE !== 1'b0 || dif.ResultE !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: busy=%b done=%b result=0x%08h, required 0 0 0",
                     dif.DivBusyE, dif.DivDoneE, dif.ResultE);
        end
        $display("async reset: busy=%b done=%b result=0x%08h", dif.DivBusyE, dif.DivDoneE, dif.ResultE);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("DIVU 1000/3", 3'b101, 32'd1000, 32'd3, 32'd333, 35, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        dif.StartE = 1'b0;
        dif.FlushE = 1'b0;
        dif.AckE   = 1'b0;
        dif.Funct3E = 3'b000;
        dif.ForwardedSrcAE = '0;
        dif.ForwardedSrcBE = '0;
        test_reset();
        test_arith();
        test_special();
        test_start_while_busy();
        test_flush();
        test_hold_and_ack_start();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
